// File: rtl/note_pkg.sv
// Shared definitions for the note tone generator: note indices, half-period
// table and FSM state type.
package note_pkg;

  localparam int unsigned NOTE_W    = 3;
  localparam int unsigned NUM_NOTES = 8;

  // Indices follow the decoder bit order of note_en.
  localparam logic [NOTE_W-1:0] NOTE_G6 = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_F6 = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_D6 = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_B7 = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_C6 = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_A7 = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_E6 = 3'd6;
  localparam logic [NOTE_W-1:0] NOTE_C7 = 3'd7;

  // Table is valid for a 1 MHz system clock.
  localparam int unsigned HALF_CLK_HZ = 1000000;
  localparam int unsigned HALF_MAX    = 478;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Half-period in clock cycles, round(CLK_HZ / (2 * f_note)).
  function automatic int unsigned half_period(input logic [NOTE_W-1:0] idx);
    int unsigned hp;
    case (idx)
      NOTE_G6: hp = 319;
      NOTE_F6: hp = 358;
      NOTE_D6: hp = 426;
      NOTE_B7: hp = 127;
      NOTE_C6: hp = 478;
      NOTE_A7: hp = 142;
      NOTE_E6: hp = 379;
      NOTE_C7: hp = 239;
      default: hp = 478;
    endcase
    return hp;
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder for the note select lines: lowest set bit wins, and
// multi flags more than one bit set.
module onehot_prio_enc
  import note_pkg::*;
(
  input  logic [NUM_NOTES-1:0] onehot,
  output logic [NOTE_W-1:0]    idx,
  output logic                 vld,
  output logic                 multi
);

  always_comb begin
    idx   = '0;
    vld   = 1'b0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        idx = NOTE_W'(i);
        vld = 1'b1;
      end
    end
    multi = ($countones(onehot) > 1);
  end

endmodule

// File: rtl/note_tone_gen.sv
// Turns the one-hot note select into a square wave, switching notes only on
// half-period boundaries so the buzzer never sees a runt pulse.
module note_tone_gen
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ = 1000000,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_NOTES-1:0] note_en,
  input  logic                 mute,
  output logic                 tone,
  output logic                 playing,
  output logic [NOTE_W-1:0]    cur_note,
  output logic                 multi_hot
);

  if (HALF_MAX - 1 >= (1 << CNT_W)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for the largest half-period");
  end

  if (CLK_HZ != HALF_CLK_HZ) begin : g_clk_chk
    $error("half-period table assumes a 1 MHz clock");
  end

  state_e               state_q, state_d;
  logic [NUM_NOTES-1:0] note_q, note_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tone_q, tone_d;
  logic                 playing_q, playing_d;
  logic [NOTE_W-1:0]    cur_note_q, cur_note_d;
  logic                 multi_hot_q, multi_hot_d;

  logic [NOTE_W-1:0]    sel_idx;
  logic                 sel_vld;
  logic                 sel_multi;
  logic [CNT_W-1:0]     sel_load;

  onehot_prio_enc u_enc (
    .onehot (note_q),
    .idx    (sel_idx),
    .vld    (sel_vld),
    .multi  (sel_multi)
  );

  assign sel_load = CNT_W'(half_period(sel_idx) - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tone_d      = tone_q;
    playing_d   = playing_q;
    cur_note_d  = cur_note_q;
    note_d      = note_en;
    multi_hot_d = sel_multi;

    if (mute) begin
      state_d    = IDLE;
      tone_d     = 1'b0;
      playing_d  = 1'b0;
      cnt_d      = '0;
      cur_note_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tone_d     = 1'b0;
          playing_d  = 1'b0;
          cur_note_d = '0;
          if (sel_vld) begin
            state_d    = PLAY;
            tone_d     = 1'b1;
            playing_d  = 1'b1;
            cnt_d      = sel_load;
            cur_note_d = sel_idx;
          end
        end
        PLAY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (sel_vld) begin
            // Half-period expiry: the only point a new note is adopted.
            tone_d     = ~tone_q;
            cnt_d      = sel_load;
            cur_note_d = sel_idx;
          end else begin
            state_d    = IDLE;
            tone_d     = 1'b0;
            playing_d  = 1'b0;
            cur_note_d = '0;
          end
        end
        default: begin
          state_d    = IDLE;
          tone_d     = 1'b0;
          playing_d  = 1'b0;
          cnt_d      = '0;
          cur_note_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      note_q      <= '0;
      cnt_q       <= '0;
      tone_q      <= 1'b0;
      playing_q   <= 1'b0;
      cur_note_q  <= '0;
      multi_hot_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      cnt_q       <= cnt_d;
      tone_q      <= tone_d;
      playing_q   <= playing_d;
      cur_note_q  <= cur_note_d;
      multi_hot_q <= multi_hot_d;
    end
  end

  assign tone      = tone_q;
  assign playing   = playing_q;
  assign cur_note  = cur_note_q;
  assign multi_hot = multi_hot_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: an event-time model checked every cycle, plus
// directed waveform measurements with hand-computed lengths.
module tb_note_tone_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] note_en;
  logic       mute;
  logic       tone;
  logic       playing;
  logic [2:0] cur_note;
  logic       multi_hot;

  int n_tests = 0;
  int n_fail  = 0;

  note_tone_gen #(.CLK_HZ(1000000), .CNT_W(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_en   (note_en),
    .mute      (mute),
    .tone      (tone),
    .playing   (playing),
    .cur_note  (cur_note),
    .multi_hot (multi_hot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: tracks the absolute cycle at which the current half-period ends.
  int unsigned half_tbl [8] = '{319, 358, 426, 127, 478, 142, 379, 239};

  function automatic int low_idx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  longint     cyc     = 0;
  longint     m_exp   = 0;
  bit         started = 0;
  logic       m_tone  = 0;
  logic       m_play  = 0;
  logic [2:0] m_cur   = 0;
  logic       m_multi = 0;
  logic [7:0] m_note  = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    started = 1;
    if (!rst_n) begin
      m_tone = 0; m_play = 0; m_cur = 0; m_multi = 0; m_note = 0;
    end else begin
      m_multi = ($countones(m_note) > 1);
      if (mute) begin
        m_tone = 0; m_play = 0; m_cur = 0;
      end else if (!m_play) begin
        if (m_note != 0) begin
          m_play = 1; m_tone = 1;
          m_cur  = 3'(low_idx(m_note));
          m_exp  = cyc + longint'(half_tbl[m_cur]);
        end
      end else if (cyc == m_exp) begin
        if (m_note != 0) begin
          m_tone = ~m_tone;
          m_cur  = 3'(low_idx(m_note));
          m_exp  = cyc + longint'(half_tbl[m_cur]);
        end else begin
          m_play = 0; m_tone = 0; m_cur = 0;
        end
      end
      m_note = note_en;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk($sformatf("tone@%0d", cyc), 32'(tone), 32'(m_tone));
      chk($sformatf("playing@%0d", cyc), 32'(playing), 32'(m_play));
      chk($sformatf("cur_note@%0d", cyc), 32'(cur_note), 32'(m_cur));
      chk($sformatf("multi_hot@%0d", cyc), 32'(multi_hot), 32'(m_multi));
    end
  end

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tone === lvl && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_tone(input logic lvl);
    int n = 0;
    while (tone !== lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("wait_tone", 32'(tone), 32'(lvl));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (playing !== 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("wait_idle", 32'(playing), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; note_en = 8'h00; mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tone", 32'(tone), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_cur", 32'(cur_note), 0);
    chk("rst_multi", 32'(multi_hot), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", 32'(playing), 0);

    // G6 steady tone
    note_en = 8'h01;
    @(negedge clk); chk("g6_edge1", 32'(tone), 0);
    @(negedge clk); chk("g6_edge2", 32'(tone), 1);
    chk("g6_playing", 32'(playing), 1);
    chk("g6_cur", 32'(cur_note), 0);
    run_len(1'b1, n); chk("g6_high", n, 319);
    run_len(1'b0, n); chk("g6_low", n, 319);
    run_len(1'b1, n); chk("g6_high2", n, 319);
    note_en = 8'h00;
    wait_idle();

    // C6 switched to A7 100 cycles into a high phase
    note_en = 8'h10;
    wait_tone(1'b1);
    chk("c6_cur", 32'(cur_note), 4);
    n = 0;
    while (tone === 1'b1 && n < 5000) begin
      n++;
      if (n == 100) note_en = 8'h20;
      @(negedge clk);
    end
    chk("c6_high_kept", n, 478);
    chk("a7_cur", 32'(cur_note), 5);
    run_len(1'b0, n); chk("a7_low", n, 142);
    run_len(1'b1, n); chk("a7_high", n, 142);
    note_en = 8'h00;
    wait_idle();

    // Multi-hot select, then single B7
    note_en = 8'h09;
    @(negedge clk); chk("mh_edge1", 32'(multi_hot), 0);
    @(negedge clk); chk("mh_edge2", 32'(multi_hot), 1);
    chk("mh_tone", 32'(tone), 1);
    chk("mh_cur", 32'(cur_note), 0);
    repeat (10) @(negedge clk);
    note_en = 8'h08;
    @(negedge clk); chk("mh_lag", 32'(multi_hot), 1);
    @(negedge clk); chk("mh_clear", 32'(multi_hot), 0);
    chk("mh_cur_hold", 32'(cur_note), 0);
    run_len(1'b1, n);
    chk("b7_adopt", 32'(cur_note), 3);
    run_len(1'b0, n); chk("b7_low", n, 127);
    run_len(1'b1, n); chk("b7_high", n, 127);

    // Stop during a low phase
    note_en = 8'h00;
    n = 0;
    while (playing === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("stop_low_len", n, 127);
    chk("stop_low_tone", 32'(tone), 0);

    // Stop during a high phase
    note_en = 8'h08;
    wait_tone(1'b1);
    repeat (5) @(negedge clk);
    note_en = 8'h00;
    run_len(1'b1, n); chk("stop_high_len", n, 122);
    chk("stop_high_idle", 32'(playing), 0);

    // Short glitch ignored, then gap-free switch to C6
    note_en = 8'h08;
    wait_tone(1'b1);
    note_en = 8'h01;
    repeat (3) @(negedge clk);
    note_en = 8'h08;
    run_len(1'b1, n); chk("glitch_high", n, 124);
    note_en = 8'h00;
    repeat (4) @(negedge clk);
    note_en = 8'h10;
    run_len(1'b0, n); chk("nogap_low", n, 123);
    chk("nogap_cur", 32'(cur_note), 4);
    chk("nogap_playing", 32'(playing), 1);
    run_len(1'b1, n); chk("nogap_high", n, 478);

    // Mute pulse mid-phase
    repeat (20) @(negedge clk);
    mute = 1'b1;
    @(negedge clk);
    chk("mute_tone", 32'(tone), 0);
    chk("mute_playing", 32'(playing), 0);
    chk("mute_cur", 32'(cur_note), 0);
    mute = 1'b0;
    @(negedge clk);
    chk("mute_restart", 32'(tone), 1);
    chk("mute_restart_cur", 32'(cur_note), 4);
    run_len(1'b1, n); chk("mute_full_half", n, 478);

    // Mute on the expiry edge wins
    repeat (477) @(negedge clk);
    mute = 1'b1;
    @(negedge clk);
    chk("mute_vs_exp_tone", 32'(tone), 0);
    chk("mute_vs_exp_play", 32'(playing), 0);
    repeat (5) @(negedge clk);
    chk("mute_hold", 32'(playing), 0);
    mute = 1'b0;
    @(negedge clk);
    chk("unmute_restart", 32'(tone), 1);

    // Reset mid-PLAY
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_tone", 32'(tone), 0);
    chk("rstmid_playing", 32'(playing), 0);
    chk("rstmid_cur", 32'(cur_note), 0);
    chk("rstmid_multi", 32'(multi_hot), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); chk("post_rst_edge1", 32'(tone), 0);
    @(negedge clk); chk("post_rst_edge2", 32'(tone), 1);
    note_en = 8'h00;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Downstream consumer of the 3-bit counter plus 3-to-8 decoder note selector. It takes the decoder's one-hot buzzer lines and turns the selected note into an audible square wave for one physical buzzer/speaker pin.
- It divides the system clock by a per-note half-period constant.
- Note changes are glitch-free: a new note takes effect only at a half-period boundary.
- It reports the active note index and flags illegal multi-hot selections.

Parameters:
- CLK_HZ, 1000000: system clock frequency in Hz. Used only to document and check the half-period table.
- CNT_W, 9: half-period counter width. It must hold the largest half-period minus 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- note_en  in  8  one-hot note select, bit order fixed: [0]=G6 [1]=F6 [2]=D6 [3]=B7 [4]=C6 [5]=A7 [6]=E6 [7]=C7
- mute  in  1  synchronous force-silence
- tone  out  1  square-wave drive to buzzer
- playing  out  1  high while state is PLAY
- cur_note  out  3  index of note currently sounding; 0 when idle
- multi_hot  out  1  high while the registered note_en has more than one bit set

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: tone=0, playing=0, cur_note=0, multi_hot=0, state=IDLE, cnt=0, note_q=0.
- Input stage: note_en is registered into note_q every cycle. All decisions use note_q only.
- Priority encode of note_q:
  - The lowest set index wins, giving sel_idx and sel_vld.
  - multi_hot is the registered popcount(note_q)>1, so it has one cycle of lag relative to note_q.
- Half-period table HALF[idx], in clock cycles at CLK_HZ=1e6, computed as round(CLK_HZ/(2*f)):
  - G6=319, F6=358, D6=426, B7=127
  - C6=478, A7=142, E6=379, C7=239
- State IDLE:
  - tone=0, playing=0, cur_note=0.
  - If sel_vld and !mute: next state PLAY, tone<=1, cnt<=HALF[sel_idx]-1, cur_note<=sel_idx.
  - Resulting latency: tone rises on the 2nd rising edge after note_en is applied.
- State PLAY:
  - If cnt!=0: cnt decrements each cycle.
  - At cnt==0 (half-period expiry) with sel_vld: tone toggles, cnt<=HALF[sel_idx]-1, cur_note<=sel_idx. A changed note is adopted here and only here.
  - At cnt==0 with !sel_vld: tone<=0, next state IDLE, cur_note<=0.
  - A steady note gives period exactly 2*HALF cycles at 50% duty.
- mute:
  - Highest priority after reset, effective next edge.
  - Next state IDLE, tone<=0, cnt<=0, cur_note<=0.
  - While mute is held, IDLE does not leave.
- Boundary conditions:
  - note_en changes and returns within one half-period: no effect on the waveform.
  - note_en goes to 0 then to a new note before expiry: the new note is adopted at expiry with no gap.
  - Expiry and mute in the same cycle: mute wins.
  - rst_n low mid-PLAY: all outputs are at reset values after that edge.
  - Same note re-selected: no phase disturbance.

Decomposition:
- Shared package note_pkg holds:
  - note index constants NOTE_G6..NOTE_C7 (0..7, matching the decoder bit order above)
  - localparam array / function half_period(idx) returning the table above
  - state enum {IDLE, PLAY}
- One sub-module: onehot_prio_enc (8-bit input; outputs idx[2:0], vld, multi).
- Compile-time check: max(HALF)-1 < 2**CNT_W.

Test Plan:
- Reset with note_en=8'h00, rst_n held low 3 cycles -> tone=0, playing=0, cur_note=0 throughout; remain IDLE after release.
- note_en=8'h01 (G6) from cycle 0 -> tone rises at edge 2; high 319 cycles, low 319 cycles, period 638; playing=1; cur_note=0.
- C6 (8'h10) playing, switched to A7 (8'h20) 100 cycles into a high phase -> high phase still lasts 478 cycles; afterwards half-periods are 142; cur_note changes 4->5 exactly at that expiry.
- note_en=8'h09 -> G6 plays (cur_note=0), multi_hot=1 from edge 2 on. Then note_en=8'h08 -> multi_hot=0 next cycle; B7 (127) adopted at next expiry.
- B7 playing, note_en=0 during a low phase -> tone stays 0; playing drops at expiry. Repeat during a high phase -> tone falls at expiry and stays 0.
- mute pulsed 1 cycle mid-phase -> tone=0, playing=0 the next cycle. Then tone restarts high one edge after mute deasserts (note still selected), with a full half-period. rst_n low mid-PLAY -> same outputs as the reset case.
